// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: frames SPI slave bytes into burst register read/write
// transactions and preloads the slave's transmit byte for every slot.
`timescale 1ns/1ps
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W      = 7,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5,
    parameter logic [7:0]  PAD_BYTE    = 8'h00,
    parameter int unsigned FLAG_HOLD   = 4
) (
    input  logic              clk_200m,
    input  logic              rst,
    input  logic              cs,
    input  logic [7:0]        recv_data,
    input  logic              recv_done,
    output logic [7:0]        send_data,
    output logic              send_flag,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wr_data,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rd_data,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(FLAG_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        CMD,
        WR,
        RD_FETCH,
        RD_LOAD,
        RD_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic              cs_s1, cs_s2, cs_d;
    logic              cs_fall, cs_rise;
    logic              recv_d, byte_evt;
    logic [7:0]        data_r;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  hold_cnt;
    logic              load;
    logic [7:0]        load_data;
    logic              addr_ld, addr_inc;

    assign cs_fall     = cs_d & ~cs_s2;
    assign cs_rise     = ~cs_d & cs_s2;
    assign reg_addr    = addr;
    assign reg_wr_data = data_r;
    assign busy        = (state != IDLE);

    // CS synchroniser and edge history; cleared to "low" on reset so a CS
    // already low at release cannot fake a fall -- a fresh fall is required.
    always_ff @(posedge clk_200m) begin
        if (rst) begin
            cs_s1 <= 1'b0;
            cs_s2 <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            cs_s1 <= cs;
            cs_s2 <= cs_s1;
            cs_d  <= cs_s2;
        end
    end

    // Byte event on recv_done rise; the byte is captured with the event so
    // it stays valid regardless of how long recv_done is held.
    always_ff @(posedge clk_200m) begin
        if (rst) begin
            recv_d   <= 1'b0;
            byte_evt <= 1'b0;
            data_r   <= '0;
        end else begin
            recv_d   <= recv_done;
            byte_evt <= recv_done & ~recv_d;
            if (recv_done && !recv_d)
                data_r <= recv_data;
        end
    end

    // State register.
    always_ff @(posedge clk_200m) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and strobe decode; CS edges take priority over byte events.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_data = PAD_BYTE;
        addr_ld   = 1'b0;
        addr_inc  = 1'b0;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else if (cs_fall) begin
            state_nxt = PRELOAD;
        end else begin
            case (state)
                IDLE: ;
                PRELOAD: begin
                    load      = 1'b1;
                    load_data = STATUS_BYTE;
                    state_nxt = CMD;
                end
                CMD: begin
                    if (byte_evt) begin
                        addr_ld = 1'b1;
                        if (data_r[7]) begin
                            state_nxt = RD_FETCH;
                        end else begin
                            load      = 1'b1;
                            state_nxt = WR;
                        end
                    end
                end
                WR: begin
                    if (byte_evt) begin
                        reg_wr_en = 1'b1;
                        addr_inc  = 1'b1;
                        load      = 1'b1;
                    end
                end
                RD_FETCH: begin
                    reg_rd_en = 1'b1;
                    state_nxt = RD_LOAD;
                end
                RD_LOAD: begin
                    load      = 1'b1;
                    load_data = reg_rd_data;
                    state_nxt = RD_WAIT;
                end
                RD_WAIT: begin
                    if (byte_evt) begin
                        addr_inc  = 1'b1;
                        state_nxt = RD_FETCH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Register address: loaded from the command byte, bumped per data byte.
    always_ff @(posedge clk_200m) begin
        if (rst)
            addr <= '0;
        else if (addr_ld)
            addr <= data_r[ADDR_W-1:0];
        else if (addr_inc)
            addr <= addr + ADDR_W'(1);
    end

    // Transmit preload: latch the byte and hold send_flag for FLAG_HOLD cycles.
    always_ff @(posedge clk_200m) begin
        if (rst) begin
            send_data <= '0;
            send_flag <= 1'b0;
            hold_cnt  <= '0;
        end else if (cs_rise) begin
            send_flag <= 1'b0;
            hold_cnt  <= '0;
        end else if (load) begin
            send_data <= load_data;
            send_flag <= 1'b1;
            hold_cnt  <= CNT_W'(FLAG_HOLD - 1);
        end else if (hold_cnt != '0) begin
            hold_cnt  <= hold_cnt - CNT_W'(1);
        end else begin
            send_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: scoreboard bench for spi_reg_ctrl with a behavioural
// register bank and a byte-level model of the SPI slave handshake.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

    logic       clk_200m = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic [7:0] recv_data = '0;
    logic       recv_done = 1'b0;
    logic [7:0] send_data;
    logic       send_flag;
    logic [6:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = '0;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [6:0] rq[$];
    logic [7:0] mq[$];
    logic [7:0] mem [128];
    logic       flag_q = 1'b0;
    int         hi_cnt = 0;
    int         last_width = 0;

    spi_reg_ctrl #(
        .ADDR_W(7),
        .STATUS_BYTE(8'hA5),
        .PAD_BYTE(8'h00),
        .FLAG_HOLD(4)
    ) dut (
        .clk_200m(clk_200m),
        .rst(rst),
        .cs(cs),
        .recv_data(recv_data),
        .recv_done(recv_done),
        .send_data(send_data),
        .send_flag(send_flag),
        .reg_addr(reg_addr),
        .reg_wr_en(reg_wr_en),
        .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .busy(busy)
    );

    always #2.5 clk_200m = ~clk_200m;

    // Register bank model: read data one cycle after the strobe.
    always @(posedge clk_200m) begin
        if (reg_rd_en) reg_rd_data <= mem[reg_addr];
        if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk_200m) begin
        if (!rst) begin
            if (reg_wr_en && reg_rd_en) begin
                compared++; mismatched++;
                $display("FAIL strobe_both: wr_en=1 rd_en=1 required not both");
            end
            if ((reg_wr_en || reg_rd_en) && !busy) begin
                compared++; mismatched++;
                $display("FAIL strobe_idle: strobe while busy=0");
            end
            if (reg_wr_en) begin
                compared++;
                if (wq.size() == 0) begin
                    mismatched++;
                    $display("FAIL write_unexpected: got addr=%02h data=%02h required no write", reg_addr, reg_wr_data);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    if (reg_addr !== e.a || reg_wr_data !== e.d) begin
                        mismatched++;
                        $display("FAIL write: got addr=%02h data=%02h required addr=%02h data=%02h", reg_addr, reg_wr_data, e.a, e.d);
                    end
                end
            end
            if (reg_rd_en) begin
                compared++;
                if (rq.size() == 0) begin
                    mismatched++;
                    $display("FAIL read_unexpected: got addr=%02h required no read", reg_addr);
                end else begin
                    logic [6:0] ea;
                    ea = rq.pop_front();
                    if (reg_addr !== ea) begin
                        mismatched++;
                        $display("FAIL read_addr: got %02h required %02h", reg_addr, ea);
                    end
                end
            end
            if (send_flag && !flag_q) begin
                compared++;
                if (mq.size() == 0) begin
                    mismatched++;
                    $display("FAIL miso_unexpected: got preload %02h required none", send_data);
                end else begin
                    logic [7:0] em;
                    em = mq.pop_front();
                    if (send_data !== em) begin
                        mismatched++;
                        $display("FAIL miso: got %02h required %02h", send_data, em);
                    end
                end
            end
        end
        if (send_flag) hi_cnt <= hi_cnt + 1;
        else begin
            if (flag_q) last_width <= hi_cnt;
            hi_cnt <= 0;
        end
        flag_q <= send_flag;
    end

    task automatic frame_begin();
        mq.push_back(8'hA5);
        @(negedge clk_200m); cs = 1'b0;
        repeat (20) @(negedge clk_200m);
    endtask

    task automatic frame_end();
        @(negedge clk_200m); cs = 1'b1;
        repeat (10) @(negedge clk_200m);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_200m); recv_data = b; recv_done = 1'b1;
        repeat (2) @(negedge clk_200m);
        recv_done = 1'b0;
        repeat (30) @(negedge clk_200m);
    endtask

    task automatic check_drained(input string name);
        compared++;
        if (wq.size() != 0 || rq.size() != 0 || mq.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drained: pending wr=%0d rd=%0d miso=%0d required 0/0/0", name, wq.size(), rq.size(), mq.size());
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_busy: got %b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_200m);
        compared++;
        if ({send_data, send_flag, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got sd=%02h sf=%b ad=%02h we=%b wd=%02h re=%b bz=%b required all 0",
                     send_data, send_flag, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk_200m);
    endtask

    task automatic test_write_burst();
        frame_begin();
        compared++;
        if (last_width != 4) begin
            mismatched++;
            $display("FAIL flag_width: got %0d required 4", last_width);
        end
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL frame_busy: got %b required 1", busy);
        end
        mq.push_back(8'h00);
        send_byte(8'h10);
        wq.push_back('{7'h10, 8'h11}); mq.push_back(8'h00);
        send_byte(8'h11);
        wq.push_back('{7'h11, 8'h22}); mq.push_back(8'h00);
        send_byte(8'h22);
        wq.push_back('{7'h12, 8'h33}); mq.push_back(8'h00);
        send_byte(8'h33);
        frame_end();
        check_drained("write_burst");
    endtask

    task automatic test_read_burst();
        mem[7'h20] = 8'h5C;
        mem[7'h21] = 8'hC3;
        frame_begin();
        rq.push_back(7'h20); mq.push_back(8'h5C);
        send_byte(8'hA0);
        rq.push_back(7'h21); mq.push_back(8'hC3);
        send_byte(8'hFF);
        rq.push_back(7'h22); mq.push_back(mem[7'h22]);
        send_byte(8'h00);
        frame_end();
        check_drained("read_burst");
    endtask

    task automatic test_wrap();
        frame_begin();
        mq.push_back(8'h00);
        send_byte(8'h7F);
        wq.push_back('{7'h7F, 8'hAA}); mq.push_back(8'h00);
        send_byte(8'hAA);
        wq.push_back('{7'h00, 8'hBB}); mq.push_back(8'h00);
        send_byte(8'hBB);
        frame_end();
        check_drained("wrap");
    endtask

    task automatic test_abort();
        frame_begin();
        mq.push_back(8'h00);
        send_byte(8'h05);
        repeat (10) @(negedge clk_200m);
        frame_end();
        check_drained("abort");
        frame_begin();
        mq.push_back(8'h00);
        send_byte(8'h06);
        wq.push_back('{7'h06, 8'h77}); mq.push_back(8'h00);
        send_byte(8'h77);
        frame_end();
        check_drained("abort_next");
    endtask

    task automatic test_collision();
        frame_begin();
        mq.push_back(8'h00);
        send_byte(8'h08);
        // CS rise and byte event land in the same cycle (sync depth 2 vs 1).
        @(negedge clk_200m); cs = 1'b1;
        @(negedge clk_200m); recv_data = 8'h99; recv_done = 1'b1;
        repeat (2) @(negedge clk_200m);
        recv_done = 1'b0;
        repeat (10) @(negedge clk_200m);
        compared++;
        if (send_flag !== 1'b0) begin
            mismatched++;
            $display("FAIL collision_flag: got %b required 0", send_flag);
        end
        check_drained("collision");
    endtask

    task automatic test_reset_mid_read();
        frame_begin();
        rq.push_back(7'h20); mq.push_back(8'h5C);
        send_byte(8'hA0);
        @(negedge clk_200m); rst = 1'b1;
        @(posedge clk_200m); #1;
        compared++;
        if ({send_data, send_flag, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy} !== '0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got sd=%02h sf=%b ad=%02h we=%b wd=%02h re=%b bz=%b required all 0",
                     send_data, send_flag, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy);
        end
        repeat (3) @(negedge clk_200m);
        rst = 1'b0;
        send_byte(8'h55);
        send_byte(8'h66);
        check_drained("midreset");
        frame_end();
        frame_begin();
        mq.push_back(8'h00);
        send_byte(8'h30);
        wq.push_back('{7'h30, 8'h44}); mq.push_back(8'h00);
        send_byte(8'h44);
        frame_end();
        check_drained("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'((i * 7 + 3) & 8'hFF);
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_abort();
        test_collision();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Transaction controller that sequences the byte-level SPI slave to give an SPI master burst read/write access to an internal register file.
- Watches CS framing and the slave's receive strobe.
- Decodes the first byte of each frame as a command and auto-increments the address per data byte.
- Preloads the slave's transmit byte (status, pad or read data) before every byte slot.
- Sits between the SPI slave and the control/status register bank in the demodulator top level.

Parameters:
- ADDR_W, 7: register address width; equals command byte bits [6:0].
- STATUS_BYTE, 8'hA5: byte shifted out during the command slot.
- PAD_BYTE, 8'h00: byte shifted out during write-data slots.
- FLAG_HOLD, 4: cycles send_flag is held high per preload.

Ports:
- clk_200m  in  1  system clock, 200 MHz.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  raw SPI chip select, active low, asynchronous to clk_200m.
- recv_data  in  8  byte from SPI slave; valid while recv_done high.
- recv_done  in  1  slave receive-complete level (high ~2 cycles per byte).
- send_data  out  8  byte to SPI slave.
- send_flag  out  1  transmit request to SPI slave.
- reg_addr  out  ADDR_W  register address.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  8  write data; valid with reg_wr_en.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  8  read data; valid exactly 1 cycle after reg_rd_en.
- busy  out  1  high while a frame is active (state != IDLE).

Behaviour:
- Reset: all outputs 0, state IDLE, address 0. Reset applies on any cycle, including mid-frame; the next frame is only recognised on a fresh CS fall after reset is released.
- cs passes through a 2-flop synchroniser.
  - cs_fall = synced 1->0.
  - cs_rise = synced 0->1.
- byte_evt = registered recv_done 0->1 edge: one event per byte, whatever the pulse length.
- send_flag preload: drive send_data, then hold send_flag high for FLAG_HOLD cycles, then drop it to 0.
  - A new preload restarts the hold counter.
  - SCLK half-period must be >= 10 clk_200m cycles. This guarantees the preload lands before the first falling edge of the next byte slot.
- Frame control (priority):
  - cs_rise: go to IDLE from any state. Clear send_flag. No write for a partial or simultaneous byte.
  - cs_fall: go to PRELOAD from any state; a resync restarts the frame.
  - byte_evt: handled only after the two conditions above.
- States:
  - IDLE: wait for cs_fall.
  - PRELOAD: send_data=STATUS_BYTE, start flag hold, go to CMD. send_flag rises on the cycle after cs_fall is detected.
  - CMD: on byte_evt, latch rw=recv_data[7] and addr=recv_data[6:0].
    - rw=0: preload PAD_BYTE, go to WR.
    - rw=1: go to RD_FETCH.
  - WR: on byte_evt, in the same cycle:
    - pulse reg_wr_en with reg_addr=addr and reg_wr_data=recv_data;
    - addr <= addr+1;
    - preload PAD_BYTE;
    - stay in WR.
  - RD_FETCH: pulse reg_rd_en with reg_addr=addr, go to RD_LOAD.
  - RD_LOAD: send_data=reg_rd_data, start flag hold, go to RD_WAIT.
  - RD_WAIT: on byte_evt (MOSI data ignored), addr <= addr+1, go to RD_FETCH.
- Latency:
  - byte_evt to reg_wr_en: 0 cycles (same cycle).
  - CMD/RD_WAIT byte_evt to send_flag rise: 2 cycles.
- Address arithmetic: modulo 2^ADDR_W; 0x7F+1 wraps to 0x00.
- reg_addr holds its last value when idle.
- Strobe rules:
  - reg_wr_en and reg_rd_en are never both high.
  - No strobes occur in IDLE.
- Bursts have no length limit.

Test Plan:
- Write burst: CS low, bytes 0x10,0x11,0x22,0x33, CS high -> writes (0x10,0x11),(0x11,0x22),(0x12,0x33); MISO shows 0xA5,0x00,0x00,0x00; busy low after CS rise.
- Read burst: preload regs 0x20=0x5C, 0x21=0xC3; send 0xA0 then 2 dummy bytes -> reg_rd_en at 0x20 then 0x21; MISO 0xA5,0x5C,0xC3; no reg_wr_en.
- Wrap: write command 0x7F, data 0xAA,0xBB -> writes to 0x7F then 0x00.
- Abort: write command 0x05, then raise CS after 4 data bits -> no write strobe; state IDLE; next frame with 0x06,0x77 writes 0x77 to 0x06.
- Collision: force cs_rise in the same cycle as byte_evt in WR -> no reg_wr_en; send_flag 0.
- Reset mid-read: assert rst during RD_WAIT -> all outputs 0 next cycle; no strobes until a new CS fall.
